// File: rtl/fft_stage3.sv
// fft_stage3: third stage of the two-lane radix-2 MDC FFT pipeline.
// Scaled butterfly on the two lanes, trivial twiddle (1 or -j) on the
// difference lane, then a depth-1 commutator. Sample sequencing comes from an
// internal index counter driven by in_valid / in_sof.
module fft_stage3 #(
  parameter int width     = 12,
  parameter int frame_len = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic             in_sof,
  input  logic [width-1:0] line1_re,
  input  logic [width-1:0] line1_im,
  input  logic [width-1:0] line2_re,
  input  logic [width-1:0] line2_im,
  output logic [width-1:0] line1_3_re,
  output logic [width-1:0] line1_3_im,
  output logic [width-1:0] line2_3_re,
  output logic [width-1:0] line2_3_im,
  output logic             out_valid,
  output logic             out_sof
);

  localparam int CW = $clog2(frame_len);

  // (a +/- b) >>> 1 computed at width+1 bits; the result always fits in width.
  function automatic logic [width-1:0] half_bfly(input logic [width-1:0] a,
                                                  input logic [width-1:0] b,
                                                  input logic             sub);
    logic [width:0] t;
    if (sub) begin
      t = {a[width-1], a} - {b[width-1], b};
    end else begin
      t = {a[width-1], a} + {b[width-1], b};
    end
    return t[width:1];
  endfunction

  // Two's complement negation that maps the most negative value to the most positive.
  function automatic logic [width-1:0] neg_sat(input logic [width-1:0] x);
    if (x == {1'b1, {(width-1){1'b0}}}) begin
      return {1'b0, {(width-1){1'b1}}};
    end else begin
      return (~x) + {{(width-1){1'b0}}, 1'b1};
    end
  endfunction

  logic [CW-1:0]    r_n;
  logic             r_primed;
  logic [width-1:0] r_d2_re, r_d2_im;
  logic [width-1:0] r_m1_re, r_m1_im;

  logic [CW-1:0]    w_idx;
  logic             w_sel;
  logic             w_emit;
  logic [width-1:0] w_s_re, w_s_im, w_d_re, w_d_im;
  logic [width-1:0] w_x2_re, w_x2_im;
  logic [width-1:0] w_m1_nxt_re, w_m1_nxt_im;
  logic [width-1:0] w_l2_re, w_l2_im;

  // Butterfly, twiddle, commutator selection and emit decision for the current sample.
  always_comb begin
    w_idx       = r_n;
    w_sel       = 1'b0;
    w_emit      = 1'b0;
    w_s_re      = half_bfly(line1_re, line2_re, 1'b0);
    w_s_im      = half_bfly(line1_im, line2_im, 1'b0);
    w_d_re      = half_bfly(line1_re, line2_re, 1'b1);
    w_d_im      = half_bfly(line1_im, line2_im, 1'b1);
    w_x2_re     = w_d_re;
    w_x2_im     = w_d_im;
    w_m1_nxt_re = w_s_re;
    w_m1_nxt_im = w_s_im;
    w_l2_re     = r_d2_re;
    w_l2_im     = r_d2_im;

    // A start-of-frame sample is index 0 regardless of the running count.
    if (in_valid && in_sof) begin
      w_idx = {CW{1'b0}};
    end else begin
      w_idx = r_n;
    end
    w_sel = w_idx[0];

    // Odd index: multiply difference by -j.
    if (w_sel) begin
      w_x2_re     = w_d_im;
      w_x2_im     = neg_sat(w_d_re);
      w_m1_nxt_re = r_d2_re;
      w_m1_nxt_im = r_d2_im;
      w_l2_re     = w_s_re;
      w_l2_im     = w_s_im;
    end else begin
      w_x2_re     = w_d_re;
      w_x2_im     = w_d_im;
      w_m1_nxt_re = w_s_re;
      w_m1_nxt_im = w_s_im;
      w_l2_re     = r_d2_re;
      w_l2_im     = r_d2_im;
    end

    // A restart while a pair is half-filled drops that pair.
    w_emit = in_valid && r_primed && !(in_sof && r_n[0]);
  end

  // Index counter, priming flag, commutator delays and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_n        <= {CW{1'b0}};
      r_primed   <= 1'b0;
      r_d2_re    <= {width{1'b0}};
      r_d2_im    <= {width{1'b0}};
      r_m1_re    <= {width{1'b0}};
      r_m1_im    <= {width{1'b0}};
      line1_3_re <= {width{1'b0}};
      line1_3_im <= {width{1'b0}};
      line2_3_re <= {width{1'b0}};
      line2_3_im <= {width{1'b0}};
      out_valid  <= 1'b0;
      out_sof    <= 1'b0;
    end else if (in_valid) begin
      r_n       <= w_idx + CW'(1);
      r_primed  <= 1'b1;
      r_d2_re   <= w_x2_re;
      r_d2_im   <= w_x2_im;
      r_m1_re   <= w_m1_nxt_re;
      r_m1_im   <= w_m1_nxt_im;
      out_valid <= w_emit;
      out_sof   <= w_emit && (w_idx == CW'(1));
      if (w_emit) begin
        line1_3_re <= r_m1_re;
        line1_3_im <= r_m1_im;
        line2_3_re <= w_l2_re;
        line2_3_im <= w_l2_im;
      end else begin
        line1_3_re <= line1_3_re;
        line1_3_im <= line1_3_im;
        line2_3_re <= line2_3_re;
        line2_3_im <= line2_3_im;
      end
    end else begin
      out_valid <= 1'b0;
      out_sof   <= 1'b0;
    end
  end

endmodule

// File: tb/tb_fft_stage3.sv
// Self-checking bench for fft_stage3: directed steps, scoreboard of expected
// output pairs built from a per-index history of x1/x2 values.
module tb_fft_stage3;
  localparam int W  = 12;
  localparam int FL = 8;
  localparam int DW = 4 * W;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst, in_valid, in_sof;
  logic [W-1:0] line1_re, line1_im, line2_re, line2_im;
  logic [W-1:0] line1_3_re, line1_3_im, line2_3_re, line2_3_im;
  logic         out_valid, out_sof;

  fft_stage3 #(.width(W), .frame_len(FL)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_sof(in_sof),
    .line1_re(line1_re), .line1_im(line1_im),
    .line2_re(line2_re), .line2_im(line2_im),
    .line1_3_re(line1_3_re), .line1_3_im(line1_3_im),
    .line2_3_re(line2_3_re), .line2_3_im(line2_3_im),
    .out_valid(out_valid), .out_sof(out_sof)
  );

  int n_vec = 0;
  int n_err = 0;

  logic [DW:0]   q[$];
  logic [DW-1:0] last_d;
  int            mn;
  bit            mprimed;
  int            x1re[FL], x1im[FL], x2re[FL], x2im[FL];

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic int sat_neg(input int v);
    if (v == -(1 << (W - 1))) return (1 << (W - 1)) - 1;
    return -v;
  endfunction

  function automatic int rnd();
    return int'($urandom_range(4095, 0)) - 2048;
  endfunction

  // One clock: drive inputs, update model, then check outputs 1 time unit after the edge.
  task automatic step(input bit v, input bit s, input int ar, input int ai, input int br, input int bi);
    int idx, sre, sim, dre, dim;
    bit emit;
    logic [DW:0] e;
    rst = 1'b0; in_valid = v; in_sof = s;
    line1_re = W'(ar); line1_im = W'(ai); line2_re = W'(br); line2_im = W'(bi);
    emit = 1'b0;
    if (v) begin
      idx  = s ? 0 : mn;
      emit = mprimed && !(s && (mn % 2 == 1));
      sre = (ar + br) >>> 1; sim = (ai + bi) >>> 1;
      dre = (ar - br) >>> 1; dim = (ai - bi) >>> 1;
      x1re[idx] = sre; x1im[idx] = sim;
      if (idx % 2 == 1) begin
        x2re[idx] = dim; x2im[idx] = sat_neg(dre);
      end else begin
        x2re[idx] = dre; x2im[idx] = dim;
      end
      if (emit) begin
        if (idx % 2 == 1)
          e = {W'(x1re[idx-1]), W'(x1im[idx-1]), W'(x1re[idx]), W'(x1im[idx]), (idx == 1)};
        else
          e = {W'(x2re[(idx+FL-2)%FL]), W'(x2im[(idx+FL-2)%FL]),
               W'(x2re[(idx+FL-1)%FL]), W'(x2im[(idx+FL-1)%FL]), 1'b0};
        q.push_back(e);
      end
      mprimed = 1'b1;
      mn = (idx + 1) % FL;
    end
    @(posedge clk);
    #1;
    if (emit) begin
      e = q.pop_front();
      check("valid", DW'(out_valid), DW'(1'b1));
      check("data", {line1_3_re, line1_3_im, line2_3_re, line2_3_im}, e[DW:1]);
      check("sof", DW'(out_sof), DW'(e[0]));
      last_d = e[DW:1];
    end else begin
      check("novalid", DW'(out_valid), DW'(1'b0));
      check("nosof", DW'(out_sof), DW'(1'b0));
      check("hold", {line1_3_re, line1_3_im, line2_3_re, line2_3_im}, last_d);
    end
  endtask

  // Reset for a number of cycles (optionally with in_valid high), then check cleared outputs.
  task automatic do_reset(input int cycles, input bit v);
    rst = 1'b1; in_valid = v; in_sof = 1'b0;
    line1_re = 12'd100; line1_im = 12'd50; line2_re = 12'd7; line2_im = 12'd3;
    repeat (cycles) @(posedge clk);
    #1;
    mn = 0; mprimed = 1'b0; last_d = '0; q.delete();
    check("rst_valid", DW'(out_valid), DW'(1'b0));
    check("rst_sof", DW'(out_sof), DW'(1'b0));
    check("rst_data", {line1_3_re, line1_3_im, line2_3_re, line2_3_im}, {DW{1'b0}});
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_sof = 1'b0;
    line1_re = '0; line1_im = '0; line2_re = '0; line2_im = '0;
    mn = 0; mprimed = 1'b0; last_d = '0;

    // Reset then idle with junk on the data inputs.
    do_reset(3, 1'b0);
    for (int i = 0; i < 10; i++) step(1'b0, 1'b0, 5, -7, 300, -1000);

    // Ramp frame, continuous.
    for (int k = 0; k < FL; k++) step(1'b1, k == 0, k, 0, 0, k);

    // Same frame with gaps after k=2 and k=5; index 0 emits the previous x2 pair.
    for (int k = 0; k < FL; k++) begin
      step(1'b1, k == 0, k, 0, 0, k);
      if (k == 2 || k == 5) begin
        for (int g = 0; g < 3; g++) step(1'b0, 1'b1, 999, -5, 7, 1);
      end
    end

    // Boundary frame: -j saturation, truncation, overflow-free extremes.
    for (int k = 0; k < FL; k++) begin
      case (k)
        1:       step(1'b1, 1'b0, -2048, 0, 2047, 0);
        2:       step(1'b1, 1'b0, 3, -3, 0, 0);
        5:       step(1'b1, 1'b0, -2048, -2048, 2047, 2047);
        6:       step(1'b1, 1'b0, 2047, 2047, 2047, 2047);
        7:       step(1'b1, 1'b0, -2048, 2047, -2048, -2048);
        default: step(1'b1, k == 0, rnd(), rnd(), rnd(), rnd());
      endcase
    end

    // Random frame.
    for (int k = 0; k < FL; k++) step(1'b1, k == 0, rnd(), rnd(), rnd(), rnd());

    // Restart with a half-filled pair pending (counter at 3), then a full new frame.
    for (int k = 0; k < 3; k++) step(1'b1, k == 0, rnd(), rnd(), rnd(), rnd());
    for (int k = 0; k < FL; k++) step(1'b1, k == 0, 10 * k - 40, 3 - k, 2 * k, -k);

    // Reset at k=4 with in_valid high; output resumes after two accepted samples.
    for (int k = 0; k < 4; k++) step(1'b1, k == 0, rnd(), rnd(), rnd(), rnd());
    do_reset(1, 1'b1);
    step(1'b1, 1'b0, 40, -40, 6, 8);
    step(1'b1, 1'b0, -9, 17, 100, -33);
    step(1'b1, 1'b0, 500, 1, -500, 2);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1, 2, 3, 4);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
